// File: rtl/fpmul_pkg.sv
// Shared types and sizing helpers for the iterative floating-point multiplier.
package fpmul_pkg;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  // Special-operand flags captured when an operation is accepted.
  typedef struct packed {
    logic a_nan;
    logic b_nan;
    logic a_inf;
    logic b_inf;
    logic a_z;
    logic b_z;
  } spcl_t;

  function automatic int bias(input int exw);
    return (1 << (exw - 1)) - 1;
  endfunction

  function automatic logic [63:0] qnan_fract(input int fmw);
    return 64'd1 << (fmw - 1);
  endfunction

  function automatic int iterations(input int sw, input int bpc);
    return (sw + bpc - 1) / bpc;
  endfunction

endpackage

// File: rtl/fp_decomp_n.sv
// Splits an IEEE-754 operand into sign, exponent, significand and class flags.
// FPMUL_DENORMAL_EN keeps denormals as values; otherwise exponent zero means zero.
module fp_decomp_n
  import fpmul_pkg::*;
#(
  parameter int EXW = 8,
  parameter int FMW = 23
) (
  input  logic [EXW+FMW:0] x,
  output logic             sgn,
  output logic [EXW-1:0]   exp,
  output logic [FMW:0]     fract,
  output logic             xz,
  output logic             vz,
  output logic             inf,
  output logic             nan
);

  logic [EXW-1:0] xe;
  logic [FMW-1:0] f;
  logic           fz;
  logic           xo;

  assign xe    = x[EXW+FMW-1:FMW];
  assign f     = x[FMW-1:0];
  assign fz    = (f == '0);
  assign xo    = &xe;

  assign sgn   = x[EXW+FMW];
  assign exp   = xe;
  assign xz    = ~|xe;
  assign fract = {~xz, f};
  assign inf   = xo & fz;
  assign nan   = xo & ~fz;

`ifdef FPMUL_DENORMAL_EN
  assign vz = xz & fz;
`else
  assign vz = xz;
`endif

endmodule

// File: rtl/fp_multiply_seq.sv
// Iterative FP multiplier: N+1 cycles to result (1 on zero/Inf/NaN), result held until out_ready.
// FPMUL_DENORMAL_EN enables denormal operands and keeps the significand on underflow.
module fp_multiply_seq
  import fpmul_pkg::*;
#(
  parameter int EXW = 8,
  parameter int FMW = 23,
  parameter int BPC = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXW+FMW:0]      a,
  input  logic [EXW+FMW:0]      b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  o_sign,
  output logic [EXW-1:0]        o_exp,
  output logic [2*(FMW+1)-1:0]  o_sig,
  output logic                  sign_exe,
  output logic                  inf,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  nan_out
);

  localparam int              SW      = FMW + 1;
  localparam int              N       = iterations(SW, BPC);
  localparam int              CW      = $clog2(N + 1);
  localparam int              BIAS_I  = bias(EXW);
  localparam logic [63:0]     QNAN    = qnan_fract(FMW);
  localparam logic [EXW+1:0]  BIAS_V  = BIAS_I[EXW+1:0];
  localparam logic [FMW-1:0]  INF0_F  = QNAN[FMW-1:0] | {{(FMW-3){1'b0}}, 3'b100};

  logic           a_sgn, b_sgn, a_xz, b_xz, a_vz, b_vz;
  logic           a_inf, b_inf, a_nan, b_nan;
  logic [EXW-1:0] a_exp, b_exp, a_xe, b_xe;
  logic [SW-1:0]  a_fr, b_fr;

  fp_decomp_n #(.EXW(EXW), .FMW(FMW)) u_dec_a (
    .x(a), .sgn(a_sgn), .exp(a_exp), .fract(a_fr),
    .xz(a_xz), .vz(a_vz), .inf(a_inf), .nan(a_nan)
  );

  fp_decomp_n #(.EXW(EXW), .FMW(FMW)) u_dec_b (
    .x(b), .sgn(b_sgn), .exp(b_exp), .fract(b_fr),
    .xz(b_xz), .vz(b_vz), .inf(b_inf), .nan(b_nan)
  );

  // A nonzero operand with a zero exponent field is a denormal: effective exponent 1.
  assign a_xe = a_exp | {{(EXW-1){1'b0}}, a_xz & ~a_vz};
  assign b_xe = b_exp | {{(EXW-1){1'b0}}, b_xz & ~b_vz};

  logic [EXW+1:0] ex1_dec;
  spcl_t          dec_sp;
  logic           early;

  assign ex1_dec = (a_vz | b_vz) ? '0 : ({2'b00, a_xe} + {2'b00, b_xe} - BIAS_V);
  assign dec_sp  = {a_nan, b_nan, a_inf, b_inf, a_vz, b_vz};
  assign early   = |dec_sp;

  state_t          state, state_nxt;
  logic            load, step, fin;
  logic [CW-1:0]   cnt;
  logic [2*SW-1:0] mcand, acc, acc_nxt, pp;
  logic [SW-1:0]   mplier;
  logic            sgn_r, sexe_r;
  logic [EXW+1:0]  ex1_r;
  spcl_t           sp_r;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE: if (in_valid && ce) begin
        load      = 1'b1;
        state_nxt = early ? DONE : MUL;
      end
      MUL: if (ce) begin
        step = 1'b1;
        if (cnt == CW'(1)) begin
          fin       = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: if (out_ready && ce) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // The multiplicand register shifts left with each retired digit, so no barrel shifter.
  assign pp      = mcand * {{(2*SW-BPC){1'b0}}, mplier[BPC-1:0]};
  assign acc_nxt = acc + pp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      sgn_r  <= 1'b0;
      sexe_r <= 1'b0;
      ex1_r  <= '0;
      sp_r   <= '0;
    end else if (load) begin
      sgn_r  <= a_sgn ^ b_sgn;
      sexe_r <= a_sgn & b_sgn;
      ex1_r  <= ex1_dec;
      sp_r   <= dec_sp;
      mcand  <= {{SW{1'b0}}, a_fr};
      mplier <= b_fr;
      acc    <= '0;
      cnt    <= CW'(N);
    end else if (step) begin
      acc    <= acc_nxt;
      mcand  <= mcand << BPC;
      mplier <= mplier >> BPC;
      cnt    <= cnt - CW'(1);
    end
  end

  // Result is composed from live decode on early exit, from registered state after MUL.
  logic            idle, c_sgn, c_sexe;
  spcl_t           c_sp;
  logic [EXW+1:0]  c_ex1;
  logic [2*SW-1:0] c_prod;

  assign idle   = (state == IDLE);
  assign c_sgn  = idle ? (a_sgn ^ b_sgn) : sgn_r;
  assign c_sexe = idle ? (a_sgn & b_sgn) : sexe_r;
  assign c_sp   = idle ? dec_sp : sp_r;
  assign c_ex1  = idle ? ex1_dec : ex1_r;
  assign c_prod = idle ? '0 : acc_nxt;

  logic            under, over, r_nan;
  logic [EXW-1:0]  r_exp;
  logic [2*SW-1:0] r_sig;

  // NaN payloads read the live operands: NaN flags are only ever set on the accept cycle.
  always_comb begin
    under = c_ex1[EXW+1];
    over  = (&c_ex1[EXW-1:0] | c_ex1[EXW]) & ~under;
    r_exp = c_ex1[EXW-1:0];
    r_sig = c_prod;
    r_nan = 1'b0;
    if (c_sp.a_nan) begin
      r_exp = '1;
      r_sig = {2'b11, a[FMW-2:0], {SW{1'b0}}};
      r_nan = 1'b1;
    end else if (c_sp.b_nan) begin
      r_exp = '1;
      r_sig = {2'b11, b[FMW-2:0], {SW{1'b0}}};
      r_nan = 1'b1;
    end else if ((c_sp.a_inf & c_sp.b_z) | (c_sp.b_inf & c_sp.a_z)) begin
      r_exp = '1;
      r_sig = {1'b1, INF0_F, {SW{1'b0}}};
      r_nan = 1'b1;
    end else if (c_sp.a_inf | c_sp.b_inf | over) begin
      r_exp = '1;
      r_sig = '0;
    end else if (under) begin
`ifndef FPMUL_DENORMAL_EN
      r_sig = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_sign    <= 1'b0;
      o_exp     <= '0;
      o_sig     <= '0;
      sign_exe  <= 1'b0;
      inf       <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      nan_out   <= 1'b0;
    end else if ((load && early) || fin) begin
      o_sign    <= c_sgn;
      o_exp     <= r_exp;
      o_sig     <= r_sig;
      sign_exe  <= c_sexe;
      inf       <= over;
      overflow  <= over;
      underflow <= under;
      nan_out   <= r_nan;
    end
  end

endmodule
